// File: rtl/bram_stream_reader.sv
// Reads a run of words from a BRAM read port and streams them out through a
// 2-entry FIFO with valid/ready flow control. Optional macro: BRAM_RD_STRIDE_EN.
module bram_stream_reader #(
    parameter int DEPTH      = 1024,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [ADDR_WIDTH-1:0]        base_addr,
    input  logic [ADDR_WIDTH:0]          length,
`ifdef BRAM_RD_STRIDE_EN
    input  logic [ADDR_WIDTH-1:0]        stride,
`endif
    output logic                         busy,
    output logic                         done,
    output logic                         bram_enb,
    output logic [ADDR_WIDTH-1:0]        bram_addrb,
    input  logic signed [DATA_WIDTH-1:0] bram_dob,
    output logic signed [DATA_WIDTH-1:0] m_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic                         m_last
);

    if (DEPTH != (1 << ADDR_WIDTH)) begin : g_bad_depth
        $error("bram_stream_reader: DEPTH must equal 2**ADDR_WIDTH");
    end

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE_W   = (ADDR_WIDTH+1)'(1);

    state_t                      state;
    logic                        busy_q;
    logic                        done_q;
    logic [ADDR_WIDTH:0]         len_q;
    logic [ADDR_WIDTH:0]         issued;
    logic [ADDR_WIDTH-1:0]       addr_q;
`ifdef BRAM_RD_STRIDE_EN
    logic [ADDR_WIDTH-1:0]       step_q;
`else
    localparam logic [ADDR_WIDTH-1:0] step_q = ADDR_WIDTH'(1);
`endif

    // Read issued last cycle: its data is on bram_dob this cycle.
    logic                        pend_v;
    logic                        pend_last;

    logic signed [DATA_WIDTH-1:0] fifo_data [2];
    logic [1:0]                  fifo_last;
    logic                        wr_ptr;
    logic                        rd_ptr;
    logic [1:0]                  count;

    logic [1:0]                  occ;
    logic                        pop;
    logic                        credit_ok;
    logic                        issue;
    logic                        final_issue;

    // Issue is decided combinationally so a pop in this cycle frees a slot
    // for a read in this same cycle; that is what sustains one word per cycle.
    always_comb begin
        occ         = count + {1'b0, pend_v};
        pop         = m_valid && m_ready;
        credit_ok   = (occ < 2'd2) || ((occ == 2'd2) && pop);
        issue       = !rst && (state == RUN) && credit_ok;
        final_issue = issue && (issued == len_q - ONE_W);
    end

    assign bram_enb   = issue;
    assign bram_addrb = issue ? addr_q : '0;
    assign m_valid    = (count != 2'd0) && !rst;
    assign m_data     = m_valid ? fifo_data[rd_ptr] : '0;
    assign m_last     = m_valid && fifo_last[rd_ptr];
    assign busy       = busy_q && !rst;
    assign done       = done_q && !rst;

    // NOTE: the FIFO payload array has no reset; occupancy is reset, so stale
    // contents are never presented and the array can map to plain storage.
    always_ff @(posedge clk) begin
        if (pend_v) begin
            fifo_data[wr_ptr] <= bram_dob;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            len_q     <= '0;
            issued    <= '0;
            addr_q    <= '0;
`ifdef BRAM_RD_STRIDE_EN
            step_q    <= '0;
`endif
            pend_v    <= 1'b0;
            pend_last <= 1'b0;
            fifo_last <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= '0;
        end else begin
            done_q    <= 1'b0;
            pend_v    <= issue;
            pend_last <= final_issue;

            if (pend_v) begin
                fifo_last[wr_ptr] <= pend_last;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, pend_v} - {1'b0, pop};

            case (state)
                IDLE: begin
                    if (start) begin
                        if (length == '0) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state  <= RUN;
                            busy_q <= 1'b1;
                            len_q  <= (length > DEPTH_W) ? DEPTH_W : length;
                            issued <= '0;
                            addr_q <= base_addr;
`ifdef BRAM_RD_STRIDE_EN
                            step_q <= stride;
`endif
                        end
                    end
                end
                RUN: begin
                    if (issue) begin
                        addr_q <= addr_q + step_q;
                        issued <= issued + ONE_W;
                        if (final_issue) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && m_last) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Self-checking bench for bram_stream_reader: a queue-based model of the
// expected word/address stream checked every cycle, plus directed literal checks.
module tb_bram_stream_reader;

    localparam int AW    = 10;
    localparam int DW    = 16;
    localparam int DEPTH = 1024;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic                 m_ready = 1'b1;
    logic [AW-1:0]        base_addr = '0;
    logic [AW:0]          length = '0;
`ifdef BRAM_RD_STRIDE_EN
    logic [AW-1:0]        stride = '0;
`endif
    logic                 busy, done, bram_enb, m_valid, m_last;
    logic [AW-1:0]        bram_addrb;
    logic signed [DW-1:0] bram_dob = '0;
    logic signed [DW-1:0] m_data;

    bram_stream_reader #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .length     (length),
`ifdef BRAM_RD_STRIDE_EN
        .stride     (stride),
`endif
        .busy       (busy),
        .done       (done),
        .bram_enb   (bram_enb),
        .bram_addrb (bram_addrb),
        .bram_dob   (bram_dob),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // BRAM with registered read port, ram[i] = 100 + i
    int ram [DEPTH];
    always @(posedge clk) begin
        if (bram_enb) bram_dob <= DW'(ram[bram_addrb]);
    end

    typedef struct { int data; bit last; } word_t;
    word_t exp_q[$];
    int    addr_exp[$];
    int    got_q[$];
    int    addr_got[$];

    int n_cmp = 0;
    int n_bad = 0;

    bit   active = 0;
    bit   done_seen = 0;
    int   start_cyc = 0;
    int   done_cyc = -1;
    int   first_valid_cyc = -1;
    int   first_enb_cyc = -1;
    int   last_hs_cyc = -1;
    int   hs_count = 0;
    int   issued_n = 0;
    bit   prev_stall = 0;
    logic signed [DW-1:0] prev_data = '0;
    logic prev_last = 1'b0;

    task automatic check(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic check_got(input string name, input int k, input int val);
        if (k < got_q.size()) check(name, got_q[k], val);
        else check(name, -1, val);
    endtask

    task automatic check_addr(input string name, input int k, input int val);
        if (k < addr_got.size()) check(name, addr_got[k], val);
        else check(name, -1, val);
    endtask

    // Per-cycle compare against the model, sampled on the falling edge
    always @(negedge clk) begin
        if (rst) begin
            check("rst_quiet", int'(busy | done | bram_enb | m_valid | m_last |
                                    (bram_addrb != '0) | (m_data != '0)), 0);
            exp_q.delete();
            addr_exp.delete();
            active     = 0;
            prev_stall = 0;
            issued_n   = 0;
            hs_count   = 0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", int'(m_valid), 1);
                check("stall_data", int'(m_data), int'(prev_data));
                check("stall_last", int'(m_last), int'(prev_last));
            end
            if (m_valid) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                check("model_has_word", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    check("m_data", int'(m_data), exp_q[0].data);
                    check("m_last", int'(m_last), int'(exp_q[0].last));
                end
                if (m_ready) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    got_q.push_back(int'(m_data));
                    hs_count++;
                    last_hs_cyc = cyc;
                end
            end else begin
                check("m_data_idle", int'(m_data), 0);
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;

            if (bram_enb) begin
                if (first_enb_cyc < 0) first_enb_cyc = cyc;
                check("addr_expected", int'(addr_exp.size() > 0), 1);
                if (addr_exp.size() > 0) check("bram_addrb", int'(bram_addrb), addr_exp.pop_front());
                addr_got.push_back(int'(bram_addrb));
                issued_n++;
            end else begin
                check("addr_idle", int'(bram_addrb), 0);
            end
            check("outstanding_le2", int'(issued_n - hs_count <= 2), 1);

            if (done) begin
                check("done_expected", int'(active), 1);
                check("done_cycle", cyc, (hs_count > 0) ? last_hs_cyc + 1 : start_cyc + 1);
                check("all_words_out", exp_q.size(), 0);
                active    = 0;
                done_seen = 1;
                done_cyc  = cyc;
            end
            check("busy", int'(busy), int'(active && (cyc > start_cyc)));
        end
    end

    // Loads the model with the expected stream and pulses start for one cycle
    task automatic start_xfer(input int base, input int len, input int strd);
        int n;
        int a;
        n = (len > DEPTH) ? DEPTH : len;
        for (int k = 0; k < n; k++) begin
            a = (base + k * strd) % DEPTH;
            exp_q.push_back('{data: 100 + a, last: (k == n - 1)});
            addr_exp.push_back(a);
        end
        got_q.delete();
        addr_got.delete();
        hs_count        = 0;
        issued_n        = 0;
        first_valid_cyc = -1;
        first_enb_cyc   = -1;
        last_hs_cyc     = -1;
        done_seen       = 0;
        done_cyc        = -1;
        @(posedge clk); #1;
        base_addr = AW'(base);
        length    = (AW+1)'(len);
`ifdef BRAM_RD_STRIDE_EN
        stride    = AW'(strd);
`endif
        start     = 1'b1;
        start_cyc = cyc;
        active    = 1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_xfer(input int base, input int len, input int strd,
                            input bit toggle, input bit poke);
        start_xfer(base, len, strd);
        for (int t = 0; t < 3000 && !done_seen; t++) begin
            if (poke && t == 2) begin
                start     = 1'b1;
                base_addr = AW'(500);
            end else begin
                start = 1'b0;
            end
            if (toggle) m_ready = ~m_ready;
            @(posedge clk); #1;
        end
        start   = 1'b0;
        m_ready = 1'b1;
        check("done_within_bound", int'(done_seen), 1);
    endtask

    initial begin
        int t3d [4] = '{1122, 1123, 100, 101};
        int t3a [4] = '{1022, 1023, 0, 1};

        for (int i = 0; i < DEPTH; i++) ram[i] = 100 + i;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Base 0, length 4, ready held high: fixed latency and throughput
        run_xfer(0, 4, 1, 0, 0);
        check("t1_count", got_q.size(), 4);
        for (int i = 0; i < 4; i++) check_got("t1_word", i, 100 + i);
        check("t1_enb_latency", first_enb_cyc - start_cyc, 1);
        check("t1_valid_latency", first_valid_cyc - start_cyc, 3);
        check("t1_done_latency", done_cyc - start_cyc, 7);

        // Length 8, ready toggling, with a stray start mid-transfer
        run_xfer(0, 8, 1, 1, 1);
        check("t2_count", got_q.size(), 8);
        for (int i = 0; i < 8; i++) check_got("t2_word", i, 100 + i);

        // Address wrap at the top of memory
        run_xfer(1022, 4, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            check_addr("t3_addr", i, t3a[i]);
            check_got("t3_word", i, t3d[i]);
        end

        // Zero length: immediate done, no reads, no stream
        run_xfer(5, 0, 1, 0, 0);
        check("t4_done_latency", done_cyc - start_cyc, 1);
        check("t4_no_reads", issued_n, 0);
        check("t4_no_valid", first_valid_cyc, -1);

        // Oversized length clamps to memory depth
        run_xfer(0, 2000, 1, 0, 0);
        check("t5_count", got_q.size(), 1024);
        check_got("t5_final_word", 1023, 1123);

        // Reset after the third handshake, then a fresh short transfer
        start_xfer(0, 8, 1);
        for (int t = 0; t < 100 && hs_count < 3; t++) begin
            @(posedge clk); #1;
        end
        check("t6_three_before_abort", hs_count, 3);
        for (int i = 0; i < 3; i++) check_got("t6_pre_word", i, 100 + i);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        run_xfer(10, 2, 1, 0, 0);
        check("t6_count", got_q.size(), 2);
        check_got("t6_word0", 0, 110);
        check_got("t6_word1", 1, 111);

`ifdef BRAM_RD_STRIDE_EN
        run_xfer(0, 3, 3, 0, 0);
        check("t7_count", got_q.size(), 3);
        for (int i = 0; i < 3; i++) check_got("t7_word", i, 100 + 3 * i);
        run_xfer(0, 2, 0, 0, 0);
        check("t8_count", got_q.size(), 2);
        check_got("t8_word0", 0, 100);
        check_got("t8_word1", 1, 100);
`endif

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bram_stream_reader.md
BRAM_STREAM_READER -- requirements
Module: bram_stream_reader

Interface
REQ-001 SHALL have parameters: DEPTH, 1024, BRAM words; DATA_WIDTH, 16, signed fixed-point word width; ADDR_WIDTH, 10, BRAM address width.
REQ-002 SHALL require DEPTH == 2^ADDR_WIDTH.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  in  1  sole clock; all logic on posedge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 start  in  1  transfer request, sampled only in IDLE.
REQ-007 base_addr  in  ADDR_WIDTH  first read address, latched on accepted start.
REQ-008 length  in  ADDR_WIDTH+1  words to read, latched on accepted start.
REQ-009 stride  in  ADDR_WIDTH  address step; port present only with BRAM_RD_STRIDE_EN.
REQ-010 busy  out  1  high from the cycle after an accepted start until done.
REQ-011 done  out  1  one-cycle completion pulse.
REQ-012 bram_enb  out  1  BRAM read-port enable.
REQ-013 bram_addrb  out  ADDR_WIDTH  BRAM read address.
REQ-014 bram_dob  in  DATA_WIDTH signed  BRAM registered read data, valid one cycle after bram_enb.
REQ-015 m_data  out  DATA_WIDTH signed  stream data.
REQ-016 m_valid  out  1  stream valid.
REQ-017 m_ready  in  1  stream ready from the consumer.
REQ-018 m_last  out  1  high with the final word of a transfer.

Function
REQ-019 SHALL implement the FSM states IDLE, RUN, DRAIN, and DONE.
REQ-020 IDLE→RUN on start; IDLE→DONE on start with length==0; RUN→DRAIN when length reads have been issued; DRAIN→DONE on the final handshake; DONE→IDLE unconditionally.
REQ-021 SHALL clamp a length greater than DEPTH to DEPTH.
REQ-022 SHALL ignore start outside IDLE.
REQ-023 Address sequence: base_addr, then +step each issue, modulo 2^ADDR_WIDTH (1023→0 wrap); step is 1 without the macro.
REQ-024 bram_enb SHALL be high only in RUN, for one cycle per issued read; bram_addrb is 0 when bram_enb is low.
REQ-025 SHALL hold returning read data in a 2-entry output FIFO, capturing bram_dob the cycle after issue.
REQ-026 SHALL issue a read only when (FIFO occupancy + in-flight reads) < 2, or == 2 with a pop in the same cycle; the FIFO never overflows.
REQ-027 With m_ready held high, throughput SHALL be one word per cycle.
REQ-028 With start high in cycle N, bram_enb SHALL rise in cycle N+1 and the first m_valid in cycle N+3.
REQ-029 A handshake occurs when m_valid && m_ready; while m_valid is high and m_ready is low, m_data and m_last SHALL hold stable.
REQ-030 m_data SHALL be 0 whenever m_valid is low.
REQ-031 Words SHALL emerge in issue order with no drops or duplicates.
REQ-032 done SHALL be high in the cycle after the final handshake (length==0: cycle N+1), and busy low in that same cycle.
REQ-033 A new start SHALL be accepted no earlier than the cycle after done.

Reset
REQ-034 rst SHALL force IDLE, flush the FIFO, and discard in-flight reads, including mid-transfer.
REQ-035 During and after rst, SHALL drive busy, done, bram_enb, bram_addrb, m_data, m_valid, and m_last to 0.

Configuration
REQ-036 Macro BRAM_RD_STRIDE_EN: when defined, the stride port exists and the step is stride latched at start (stride 0 re-reads base_addr length times).
REQ-037 When BRAM_RD_STRIDE_EN is undefined, the stride port SHALL be absent and the step is 1.

Verification
REQ-038 ram[i]=100+i, base 0, length 4, m_ready=1, start in cycle N -> m_data 100..103 in cycles N+3..N+6, m_last with 103, done in N+7.
REQ-039 length 8, m_ready toggling 1,0,1,0 -> 100..107 in order, data stable across stalls, never more than 2 reads outstanding.
REQ-040 base 1022, length 4 -> bram_addrb 1022, 1023, 0, 1; m_data 1122, 1123, 100, 101.
REQ-041 length 0 -> done in N+1, bram_enb never high, m_valid never high; length 2000 -> exactly 1024 words emitted.
REQ-042 rst after the 3rd handshake of length 8, then start with base 10, length 2 -> only 110, 111 emitted, m_last on 111.
REQ-043 BRAM_RD_STRIDE_EN, stride 3, base 0, length 3 -> 100, 103, 106; stride 0, length 2 -> 100, 100.
